// File: rtl/inst_queue.sv
// Dual-ported instruction fetch queue: up to two instructions in and two out per cycle.
// Optional build macro IQ_PERF_CNT_EN adds internal full/empty/dual-issue cycle counters.
module inst_queue #(
   parameter int DEPTH = 16,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        in_valid1,
   input  logic [31:0] in_inst1,
   input  logic [31:0] in_pc1,
   input  logic        in_valid2,
   input  logic [31:0] in_inst2,
   input  logic [31:0] in_pc2,
   output logic        full,
   output logic        empty,
   output logic        out_valid1,
   output logic [31:0] out_inst1,
   output logic [31:0] out_pc1,
   output logic        out_valid2,
   output logic [31:0] out_inst2,
   output logic [31:0] out_pc2,
   input  logic [1:0]  deq_num
);

   localparam logic [PTR_W:0] FULL_TH = (PTR_W+1)'(DEPTH - 1);

   logic [63:0]      mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_ptr_p1, rd_ptr_p1;
   logic [PTR_W:0]   count, count_next;
   logic [1:0]       enq_num, deq_req, deq_eff;
   logic [63:0]      head0, head1;

   assign wr_ptr_p1 = wr_ptr + PTR_W'(1);
   assign rd_ptr_p1 = rd_ptr + PTR_W'(1);

   assign full  = (count >= FULL_TH);
   assign empty = (count == '0);

   // Slot 2 only counts behind slot 1; a full queue drops the whole fetch group.
   always_comb begin
      enq_num = 2'd0;
      if (in_valid1 && !full)
         enq_num = in_valid2 ? 2'd2 : 2'd1;
   end

   // Retire request is clamped to 2 and to the number of entries held before this cycle.
   always_comb begin
      deq_req = (deq_num == 2'd3) ? 2'd2 : deq_num;
      deq_eff = deq_req;
      if (count < (PTR_W+1)'(deq_req))
         deq_eff = count[1:0];
      count_next = count + (PTR_W+1)'(enq_num) - (PTR_W+1)'(deq_eff);
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + PTR_W'(enq_num);
         rd_ptr <= rd_ptr + PTR_W'(deq_eff);
         count  <= count_next;
      end
   end

   // Storage is never cleared; pointers and count alone define what is live.
   always_ff @(posedge clk) begin
      if (!rst && !flush) begin
         if (enq_num != 2'd0)
            mem[wr_ptr] <= {in_inst1, in_pc1};
         if (enq_num == 2'd2)
            mem[wr_ptr_p1] <= {in_inst2, in_pc2};
      end
   end

   assign head0 = mem[rd_ptr];
   assign head1 = mem[rd_ptr_p1];

   assign out_valid1 = (count != '0);
   assign out_valid2 = (count >= (PTR_W+1)'(2));
   assign out_inst1  = out_valid1 ? head0[63:32] : 32'd0;
   assign out_pc1    = out_valid1 ? head0[31:0]  : 32'd0;
   assign out_inst2  = out_valid2 ? head1[63:32] : 32'd0;
   assign out_pc2    = out_valid2 ? head1[31:0]  : 32'd0;

`ifdef IQ_PERF_CNT_EN
   logic [31:0] full_cycles;
   logic [31:0] empty_cycles;
   logic [31:0] dual_issue_cycles;

   // Counters survive flush so they reflect the whole run since reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         full_cycles       <= '0;
         empty_cycles      <= '0;
         dual_issue_cycles <= '0;
      end else begin
         if (full)
            full_cycles <= full_cycles + 32'd1;
         if (empty && !flush)
            empty_cycles <= empty_cycles + 32'd1;
         if (deq_eff == 2'd2)
            dual_issue_cycles <= dual_issue_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: stimulus updates an expected-contents queue,
// a negedge monitor compares every output against it; directed checks use hand values.
module tb_inst_queue;

   logic        clk = 1'b0;
   logic        rst, flush;
   logic        in_valid1, in_valid2;
   logic [31:0] in_inst1, in_pc1, in_inst2, in_pc2;
   logic [1:0]  deq_num;
   logic        full, empty, out_valid1, out_valid2;
   logic [31:0] out_inst1, out_pc1, out_inst2, out_pc2;

   int tests  = 0;
   int failed = 0;
   bit monOn  = 1'b0;
   logic [63:0] sb [$];
   logic [31:0] pc;

   always #5 clk = ~clk;

   inst_queue dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid1(in_valid1), .in_inst1(in_inst1), .in_pc1(in_pc1),
      .in_valid2(in_valid2), .in_inst2(in_inst2), .in_pc2(in_pc2),
      .full(full), .empty(empty),
      .out_valid1(out_valid1), .out_inst1(out_inst1), .out_pc1(out_pc1),
      .out_valid2(out_valid2), .out_inst2(out_inst2), .out_pc2(out_pc2),
      .deq_num(deq_num)
   );

   function automatic logic [31:0] mkInst(input logic [31:0] p);
      return p ^ 32'h1357_2468;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of stimulus, then advance the expected contents as of that edge.
   task automatic applyStimulus(input logic v1, input logic v2,
                                input logic [31:0] i1, input logic [31:0] p1,
                                input logic [31:0] i2, input logic [31:0] p2,
                                input logic [1:0] dq, input logic fl);
      int n, d;
      bit acc;
      @(negedge clk);
      in_valid1 = v1; in_valid2 = v2;
      in_inst1 = i1; in_pc1 = p1; in_inst2 = i2; in_pc2 = p2;
      deq_num = dq; flush = fl;
      @(posedge clk);
      if (fl) begin
         sb.delete();
      end else begin
         n = sb.size();
         d = (dq == 2'd3) ? 2 : int'(dq);
         if (d > n) d = n;
         if (v1 && n >= 15)
            $display("[TB] note: fetch offered while full at %0t, expecting drop", $time);
         acc = v1 && (n < 15);
         for (int k = 0; k < d; k++) void'(sb.pop_front());
         if (acc) sb.push_back({i1, p1});
         if (acc && v2) sb.push_back({i2, p2});
      end
   endtask

   task automatic dualEnq(input logic [31:0] p, input logic [1:0] dq);
      applyStimulus(1'b1, 1'b1, mkInst(p), p, mkInst(p + 32'd4), p + 32'd4, dq, 1'b0);
   endtask

   task automatic singleEnq(input logic [31:0] p);
      applyStimulus(1'b1, 1'b0, mkInst(p), p, 32'd0, 32'd0, 2'd0, 1'b0);
   endtask

   task automatic idle(input logic [1:0] dq, input logic fl);
      applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, dq, fl);
   endtask

   task automatic applyReset();
      @(negedge clk);
      monOn = 1'b0;
      rst = 1'b1; flush = 1'b0; in_valid1 = 1'b0; in_valid2 = 1'b0;
      in_inst1 = '0; in_pc1 = '0; in_inst2 = '0; in_pc2 = '0; deq_num = 2'd0;
      repeat (2) @(posedge clk);
      sb.delete();
      #1;
      rst = 1'b0;
      monOn = 1'b1;
   endtask

   // Monitor: outputs depend only on registered state, so the negedge sees a settled view.
   always @(negedge clk) begin
      if (monOn) begin
         checkOutput("mon_empty", 32'(empty), 32'(sb.size() == 0));
         checkOutput("mon_full", 32'(full), 32'(sb.size() >= 15));
         checkOutput("mon_valid1", 32'(out_valid1), 32'(sb.size() >= 1));
         checkOutput("mon_valid2", 32'(out_valid2), 32'(sb.size() >= 2));
         checkOutput("mon_pc1", out_pc1, (sb.size() >= 1) ? sb[0][31:0] : 32'd0);
         checkOutput("mon_inst1", out_inst1, (sb.size() >= 1) ? sb[0][63:32] : 32'd0);
         checkOutput("mon_pc2", out_pc2, (sb.size() >= 2) ? sb[1][31:0] : 32'd0);
         checkOutput("mon_inst2", out_inst2, (sb.size() >= 2) ? sb[1][63:32] : 32'd0);
      end
   end

   initial begin
      applyReset();
      checkOutput("rst_empty", 32'(empty), 32'd1);
      checkOutput("rst_full", 32'(full), 32'd0);
      checkOutput("rst_valid1", 32'(out_valid1), 32'd0);
      checkOutput("rst_valid2", 32'(out_valid2), 32'd0);
      checkOutput("rst_pc1", out_pc1, 32'd0);

      applyStimulus(1'b1, 1'b0, 32'h2402_0001, 32'hBFC0_0000, 32'd0, 32'd0, 2'd0, 1'b0);
      #1;
      checkOutput("first_valid1", 32'(out_valid1), 32'd1);
      checkOutput("first_inst1", out_inst1, 32'h2402_0001);
      checkOutput("first_pc1", out_pc1, 32'hBFC0_0000);
      checkOutput("first_valid2", 32'(out_valid2), 32'd0);

      idle(2'd0, 1'b1);
      #1;
      checkOutput("flush1_empty", 32'(empty), 32'd1);

      // Fill path
      pc = 32'd0;
      for (int i = 0; i < 7; i++) begin
         dualEnq(pc, 2'd0);
         pc += 32'd8;
      end
      #1;
      checkOutput("fill14_count", 32'(dut.count), 32'd14);
      checkOutput("fill14_full", 32'(full), 32'd0);
      dualEnq(pc, 2'd0);
      pc += 32'd8;
      #1;
      checkOutput("fill16_count", 32'(dut.count), 32'd16);
      checkOutput("fill16_full", 32'(full), 32'd1);
      dualEnq(pc, 2'd0);
      #1;
      checkOutput("drop_count", 32'(dut.count), 32'd16);
      checkOutput("drop_pc1", out_pc1, 32'h0);

      // Drain to rd_ptr=14, one request of 3 to exercise the clamp
      for (int i = 0; i < 7; i++) idle((i == 3) ? 2'd3 : 2'd2, 1'b0);
      #1;
      checkOutput("drain_count", 32'(dut.count), 32'd2);
      checkOutput("drain_rdptr", 32'(dut.rd_ptr), 32'd14);
      checkOutput("drain_pc1", out_pc1, 32'h38);
      for (int i = 0; i < 6; i++) begin
         dualEnq(pc, 2'd0);
         pc += 32'd8;
      end
      #1;
      checkOutput("refill_count", 32'(dut.count), 32'd14);

      // Wrap-around at full throughput
      for (int i = 0; i < 5; i++) begin
         dualEnq(pc, 2'd2);
         pc += 32'd8;
      end
      #1;
      checkOutput("wrap_count", 32'(dut.count), 32'd14);
      checkOutput("wrap_pc1", out_pc1, 32'h60);
      checkOutput("wrap_pc2", out_pc2, 32'h64);

      // Over-dequeue combined with enqueue
      idle(2'd0, 1'b1);
      singleEnq(32'h200);
      dualEnq(32'h100, 2'd2);
      #1;
      checkOutput("ovd_count", 32'(dut.count), 32'd2);
      checkOutput("ovd_pc1", out_pc1, 32'h100);
      checkOutput("ovd_pc2", out_pc2, 32'h104);

      // Flush beats same-cycle enqueue and dequeue
      idle(2'd0, 1'b1);
      for (int i = 0; i < 4; i++) dualEnq(32'h400 + 32'(i * 8), 2'd0);
      singleEnq(32'h420);
      #1;
      checkOutput("pre_flush_count", 32'(dut.count), 32'd9);
      applyStimulus(1'b1, 1'b1, mkInst(32'h500), 32'h500, mkInst(32'h504), 32'h504, 2'd1, 1'b1);
      #1;
      checkOutput("flush_count", 32'(dut.count), 32'd0);
      checkOutput("flush_empty", 32'(empty), 32'd1);
      checkOutput("flush_valid1", 32'(out_valid1), 32'd0);
      singleEnq(32'h600);
      #1;
      checkOutput("post_flush_pc1", out_pc1, 32'h600);
      checkOutput("post_flush_valid2", 32'(out_valid2), 32'd0);

      // Full-hold and dual-issue scenario (counters checked when built in)
      applyReset();
      for (int i = 0; i < 8; i++) dualEnq(32'h1000 + 32'(i * 8), 2'd0);
      idle(2'd0, 1'b0);
      idle(2'd0, 1'b0);
      idle(2'd2, 1'b0);
      idle(2'd2, 1'b0);
      #1;
      checkOutput("perf_count", 32'(dut.count), 32'd12);
      checkOutput("perf_pc1", out_pc1, 32'h1010);
`ifdef IQ_PERF_CNT_EN
      checkOutput("full_cycles", dut.full_cycles, 32'd3);
      checkOutput("dual_issue_cycles", dut.dual_issue_cycles, 32'd2);
      checkOutput("empty_cycles", dut.empty_cycles, 32'd1);
`endif

      idle(2'd0, 1'b0);
      monOn = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Dual-entry-per-cycle instruction fetch queue between the instruction cache and the dual-issue decode stage.
- Accepts 0–2 instructions per cycle from the fetch side: cache rdata1/rdata2 with ok_1/ok_2 and their PCs.
- Presents the two oldest entries to decode, which retires 0–2 per cycle.
- Decouples cache-miss bubbles from decode. Gives fetch back-pressure and a single-cycle flush for branch redirect and exceptions.

Parameters:
- DEPTH, 16, number of entries; power of two, ≥4.
- PTR_W, $clog2(DEPTH), read/write pointer width; derived, do not override.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discard all entries (redirect/exception)
- in_valid1  in  1  slot-1 instruction valid (cache ok_1 & ~stall)
- in_inst1  in  32  slot-1 instruction word
- in_pc1  in  32  slot-1 PC
- in_valid2  in  1  slot-2 instruction valid (cache ok_2)
- in_inst2  in  32  slot-2 instruction word
- in_pc2  in  32  slot-2 PC
- full  out  1  fewer than 2 free entries; fetch must stall
- empty  out  1  no valid entries
- out_valid1  out  1  head entry valid
- out_inst1  out  32  head instruction
- out_pc1  out  32  head PC
- out_valid2  out  1  head+1 entry valid
- out_inst2  out  32  head+1 instruction
- out_pc2  out  32  head+1 PC
- deq_num  in  2  entries retired by decode this cycle (0,1,2)

Behaviour:
- Storage: circular buffer of DEPTH {inst,pc} 64-bit entries.
  - wr_ptr, rd_ptr: PTR_W bits, wrap modulo DEPTH.
  - count: PTR_W+1 bits, range 0..DEPTH.
- Enqueue count enq_num:
  - 2 if in_valid1 & in_valid2.
  - 1 if in_valid1 & ~in_valid2.
  - 0 if ~in_valid1. in_valid2 without in_valid1 is ignored.
- Enqueue when full=1: inputs are dropped, pointers unchanged. Fetch is required to stall; the bench flags any in_valid1 while full.
- Write order: slot 1 goes to mem[wr_ptr], slot 2 to mem[wr_ptr+1] (wraps). wr_ptr += enq_num.
- Dequeue:
  - Effective deq = min(deq_num, count). deq_num=3 is treated as 2.
  - rd_ptr += deq. Over-dequeue never underflows count.
- Simultaneous enqueue and dequeue in one cycle: count_next = count + enq_num − deq.
  - Dequeue uses pre-cycle entries only.
  - An instruction written this cycle is visible at the outputs next cycle at the earliest (no bypass).
- Outputs are combinational from registered state:
  - out_valid1 = count≥1; out_valid2 = count≥2.
  - out_inst1/pc1 = mem[rd_ptr]; out_inst2/pc2 = mem[rd_ptr+1] (wraps).
  - Outputs are don't-care when the matching valid=0, but the bench expects 0 in that case (gate with valid).
- full = (count ≥ DEPTH−1); empty = (count == 0). Both combinational from count.
- flush:
  - Next cycle: wr_ptr=rd_ptr=count=0.
  - Flush takes priority over same-cycle enqueue and dequeue; both are discarded.
  - Memory contents are not cleared.
- Reset: wr_ptr=rd_ptr=count=0.
  - Outputs after reset: empty=1, full=0, out_valid1=out_valid2=0, out_inst*/out_pc*=0.
  - Reset has priority over flush.
- Latency: input to out_valid1 is 1 cycle when the queue is empty.
- Throughput: sustained 2 in / 2 out per cycle with no bubbles.

Optional Feature:
- Macro: IQ_PERF_CNT_EN.
- With IQ_PERF_CNT_EN defined, the block adds three internal 32-bit counters, reset to 0 and readable hierarchically in simulation:
  - full_cycles: increments each cycle full=1.
  - empty_cycles: increments each cycle empty=1 and not flush.
  - dual_issue_cycles: increments each cycle effective deq == 2.
  - A flush does not clear the counters.
- Without the macro: no counters, no extra logic; ports and timing are identical.

Test Plan:
- Reset → empty=1, full=0, out_valid1=0, out_valid2=0. Then one cycle with in_valid1=1, inst=0x24020001, pc=0xBFC00000 → next cycle out_valid1=1, out_inst1=0x24020001, out_pc1=0xBFC00000, out_valid2=0.
- Fill path: DEPTH=16, 7 cycles of dual enqueue (pcs 0x0..0x34 step 4) with deq_num=0 → count=14, full=0. One more dual enqueue → count=16, full=1. A further dual enqueue is dropped; count stays 16.
- Wrap-around: 5 cycles of continuous dual enqueue + deq_num=2 starting at count=14 (rd_ptr=14) → out_pc1/out_pc2 stay PC-consecutive across index 15→0, and count stays 14.
- Simultaneous enqueue/dequeue with over-dequeue: count=1, deq_num=2, dual enqueue of pcs 0x100/0x104 → next cycle count=2, out_pc1=0x100, out_pc2=0x104.
- Flush: count=9, and in the same cycle flush=1, in_valid1=in_valid2=1, deq_num=1 → next cycle count=0, empty=1, out_valid1=0. The enqueued pair is absent.
- IQ_PERF_CNT_EN build: hold full for 3 cycles, then 2 dual dequeues → full_cycles=3, dual_issue_cycles=2. A non-macro build compiles with the identical port list.
